// File: rtl/noise_tensor_filler.sv
// noise_tensor_filler: fills ch x side x side BRAM elements with per-lane LFSR noise,
// LANES elements per word, one beat per accepted bram_we/bram_ready handshake.
module noise_tensor_filler #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 13,
  parameter int LANES      = 1,
  parameter int MAX_CH     = 4,
  parameter int MAX_SIZE   = 5,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [2:0]                       size,
  input  logic [$clog2(MAX_CH+1)-1:0]      ch_count,
  input  logic [31:0]                      seed,
  output logic [ADDR_WIDTH-1:0]            bram_addr,
  output logic [LANES*DATA_WIDTH-1:0]      bram_wdata,
  output logic                             bram_we,
  input  logic                             bram_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted
);
  localparam int CW = $clog2(MAX_CH+1);
  localparam int LG = $clog2(LANES);
  if (DATA_WIDTH > 32 || FRAC_WIDTH >= DATA_WIDTH || LANES < 1 || LANES > 16 ||
      (LANES & (LANES - 1)) != 0) begin : g_bad_param
    $error("noise_tensor_filler: unsupported parameter set");
  end
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} state_t;
  state_t r_state, w_next;
  logic [2:0]            w_size;
  logic [CW-1:0]         w_ch;
  logic [31:0]           w_elems;
  logic [ADDR_WIDTH-1:0] r_last, r_addr;
  logic [31:0]           r_seed;
  logic                  r_aborted, w_fire;
  assign w_size  = (size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : size;
  assign w_ch    = (ch_count == '0) ? CW'(1) : (ch_count > CW'(MAX_CH)) ? CW'(MAX_CH) : ch_count;
  assign w_elems = 32'(w_ch) << (5'd4 + {1'b0, w_size, 1'b0});
  assign w_fire  = (r_state == S_FILL) && bram_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_FILL;
      // abort takes priority over completing on the last beat
      S_FILL:  w_next = abort ? S_IDLE : (w_fire && r_addr == r_last) ? S_DONE : S_FILL;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_last    <= '0;
      r_seed    <= '0;
      r_addr    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= (r_state == S_FILL) && abort;
      if (r_state == S_IDLE && start) begin
        r_last <= ADDR_WIDTH'((w_elems >> LG) - 32'd1);
        r_seed <= seed;
      end
      if (r_state == S_LOAD) r_addr <= '0;
      else if (w_fire)       r_addr <= r_addr + 1'b1;
    end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam logic [31:0] MIX = 32'(k) * 32'h9E3779B9;
    logic [31:0]           r_lfsr;
    logic [DATA_WIDTH-1:0] w_word;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                 r_lfsr <= 32'h1;
      else if (r_state == S_LOAD) r_lfsr <= ((r_seed ^ MIX) == '0) ? 32'h1 : (r_seed ^ MIX);
      else if (w_fire)            r_lfsr <= {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_word = r_lfsr[31 -: DATA_WIDTH];
    assign bram_wdata[k*DATA_WIDTH +: DATA_WIDTH] = {w_word[DATA_WIDTH-1], w_word[DATA_WIDTH-1:1]};
  end
  assign bram_addr = r_addr;
  assign bram_we   = (r_state == S_FILL);
  assign busy      = (r_state == S_LOAD) || (r_state == S_FILL);
  assign done      = (r_state == S_DONE);
  assign aborted   = r_aborted;
endmodule

// File: tb/tb_noise_tensor_filler.sv
// tb_noise_tensor_filler: randomized fills of a 4-lane filler against a per-element LFSR model.
module tb_noise_tensor_filler;
  localparam int DW = 16, L = 4, MCH = 4, MSZ = 5, AW = 16;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, bram_ready = 1;
  logic [2:0] size = 0, ch_count = 0;
  logic [31:0] seed = 0;
  logic [AW-1:0] bram_addr;
  logic [L*DW-1:0] bram_wdata;
  logic bram_we, busy, done, aborted;
  int total = 0, bad = 0;
  typedef struct {
    int beats, errs, done_n, done_cyc, abort_n, last_addr, nz;
    bit tmo;
    logic end_busy, end_we;
    logic [AW+L*DW-1:0] bad_act, bad_exp;
  } res_t;

  noise_tensor_filler #(.DATA_WIDTH(DW), .FRAC_WIDTH(13), .LANES(L), .MAX_CH(MCH),
                        .MAX_SIZE(MSZ), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .size(size),
    .ch_count(ch_count), .seed(seed), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_we(bram_we), .bram_ready(bram_ready), .busy(busy), .done(done), .aborted(aborted));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_next(input logic [31:0] s);
    return (s << 1) | (((s >> 31) ^ (s >> 21) ^ (s >> 1) ^ s) & 32'h1);
  endfunction

  function automatic logic [DW-1:0] ref_elem(input logic [31:0] s);
    logic signed [DW-1:0] w;
    w = DW'(s >> (32 - DW));
    return DW'(w >>> 1);
  endfunction

  function automatic int ref_words(input int sz, input int ch);
    int s, c;
    s = (sz > MSZ) ? MSZ : sz;
    c = (ch == 0) ? 1 : (ch > MCH) ? MCH : ch;
    return c * (4 << s) * (4 << s) / L;
  endfunction

  // Drives one fill and scores every observed beat against the lane models.
  task automatic run_fill(input logic [31:0] sd, input logic [2:0] sz, input logic [2:0] ch,
                          input bit bp, input int abort_at, input bit poke, output res_t r);
    logic [31:0] ms [L];
    logic [L*DW-1:0] ew;
    int ea, cyc, budget, fin;
    bit acc;
    r = '{default: 0};
    ea = 0; cyc = 0; fin = 0;
    budget = 8 * ref_words(sz, ch) + 20;
    for (int k = 0; k < L; k++) begin
      ms[k] = sd ^ (32'(k) * 32'h9E3779B9);
      if (ms[k] == 0) ms[k] = 32'h1;
    end
    seed = sd; size = sz; ch_count = ch; start = 1;
    @(posedge clk); #1;
    start = 0;
    while (1) begin
      if (done) begin r.done_n++; r.done_cyc = cyc; r.end_busy = busy; end
      if (aborted) begin r.abort_n++; r.end_we = bram_we; r.end_busy = busy; end
      if (fin != 0) break;
      if (done || aborted) fin = 1;
      if (bram_we) begin
        for (int k = 0; k < L; k++) ew[k*DW +: DW] = ref_elem(ms[k]);
        if (bram_addr !== AW'(ea) || bram_wdata !== ew) begin
          if (r.errs == 0) begin r.bad_act = {bram_addr, bram_wdata}; r.bad_exp = {AW'(ea), ew}; end
          r.errs++;
        end
        if (bram_wdata[DW-1:0] != 0) r.nz++;
      end
      bram_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      abort = (abort_at >= 0 && bram_we && r.beats == abort_at);
      if (poke && bram_we && r.beats == 3) begin start = 1; seed = ~sd; size = 0; ch_count = 1; end
      acc = bram_we && bram_ready;
      if (acc) r.last_addr = int'(bram_addr);
      @(posedge clk); #1;
      cyc++;
      start = 0; abort = 0;
      if (acc) begin
        r.beats++; ea++;
        for (int k = 0; k < L; k++) ms[k] = ref_next(ms[k]);
      end
      if (cyc > budget) begin r.tmo = 1; break; end
    end
    bram_ready = 1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (bram_addr !== 0) begin bad++; $display("FAIL reset_addr: got %0h want 0", bram_addr); end
    total++; if (bram_we !== 0) begin bad++; $display("FAIL reset_we: got %b want 0", bram_we); end
    total++; if (busy !== 0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (aborted !== 0) begin bad++; $display("FAIL reset_aborted: got %b want 0", aborted); end
    total++; if (bram_wdata !== 0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bram_wdata); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    res_t r;
    run_fill(32'h1, 3'd0, 3'd1, 0, -1, 0, r);
    total++; if (r.tmo) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
    total++; if (r.beats !== 4) begin bad++; $display("FAIL basic_beats: got %0d want 4", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL basic_data: got %h want %h", r.bad_act, r.bad_exp); end
    total++; if (r.done_n !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", r.done_n); end
    total++; if (r.done_cyc !== 5) begin bad++; $display("FAIL basic_done_cycle: got %0d want 5", r.done_cyc); end
    total++; if (r.end_busy !== 0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", r.end_busy); end
    total++; if (r.last_addr !== 3) begin bad++; $display("FAIL basic_last_addr: got %0d want 3", r.last_addr); end
    total++; if (r.abort_n !== 0) begin bad++; $display("FAIL basic_aborted: got %0d want 0", r.abort_n); end
  endtask

  task automatic test_multi_lane();
    res_t r;
    int sz, ch, w;
    run_fill(32'hDEADBEEF, 3'd2, 3'd3, 0, -1, 0, r);
    total++; if (r.beats !== 192) begin bad++; $display("FAIL multi_beats: got %0d want 192", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL multi_data: got %h want %h", r.bad_act, r.bad_exp); end
    total++; if (r.last_addr !== 191) begin bad++; $display("FAIL multi_last_addr: got %0d want 191", r.last_addr); end
    total++; if (r.done_cyc !== 193) begin bad++; $display("FAIL multi_done_cycle: got %0d want 193", r.done_cyc); end
    for (int i = 0; i < 3; i++) begin
      sz = $urandom_range(0, 2); ch = $urandom_range(0, 7);
      w = ref_words(sz, ch);
      run_fill($urandom, 3'(sz), 3'(ch), 0, -1, 0, r);
      total++; if (r.beats !== w) begin bad++; $display("FAIL rand_beats: got %0d want %0d", r.beats, w); end
      total++; if (r.errs !== 0) begin bad++; $display("FAIL rand_data: got %h want %h", r.bad_act, r.bad_exp); end
      total++; if (r.done_n !== 1) begin bad++; $display("FAIL rand_done: got %0d want 1", r.done_n); end
    end
  endtask

  task automatic test_clamp();
    res_t r;
    run_fill(32'h0BADF00D, 3'd2, 3'd7, 0, -1, 0, r);
    total++; if (r.beats !== 256) begin bad++; $display("FAIL ch_clamp_beats: got %0d want 256", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL ch_clamp_data: got %h want %h", r.bad_act, r.bad_exp); end
    run_fill(32'hC0FFEE11, 3'd7, 3'd1, 0, -1, 0, r);
    total++; if (r.beats !== 4096) begin bad++; $display("FAIL size_clamp_beats: got %0d want 4096", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL size_clamp_data: got %h want %h", r.bad_act, r.bad_exp); end
    total++; if (r.done_cyc !== 4097) begin bad++; $display("FAIL size_clamp_done_cycle: got %0d want 4097", r.done_cyc); end
  endtask

  task automatic test_backpressure();
    res_t r;
    for (int i = 0; i < 3; i++) begin
      run_fill($urandom, 3'd1, 3'd2, 1, -1, 0, r);
      total++; if (r.beats !== 32) begin bad++; $display("FAIL bp_beats: got %0d want 32", r.beats); end
      total++; if (r.errs !== 0) begin bad++; $display("FAIL bp_data: got %h want %h", r.bad_act, r.bad_exp); end
      total++; if (r.done_n !== 1) begin bad++; $display("FAIL bp_done: got %0d want 1", r.done_n); end
    end
  endtask

  task automatic test_abort();
    res_t r;
    run_fill(32'h13572468, 3'd1, 3'd1, 0, 5, 0, r);
    total++; if (r.beats !== 6) begin bad++; $display("FAIL abort_beats: got %0d want 6", r.beats); end
    total++; if (r.abort_n !== 1) begin bad++; $display("FAIL abort_pulse: got %0d want 1", r.abort_n); end
    total++; if (r.done_n !== 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", r.done_n); end
    total++; if (r.end_we !== 0) begin bad++; $display("FAIL abort_idle_we: got %b want 0", r.end_we); end
    total++; if (r.end_busy !== 0) begin bad++; $display("FAIL abort_idle_busy: got %b want 0", r.end_busy); end
    run_fill(32'h13572468, 3'd1, 3'd1, 0, -1, 0, r);
    total++; if (r.beats !== 16) begin bad++; $display("FAIL refill_beats: got %0d want 16", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL refill_data: got %h want %h", r.bad_act, r.bad_exp); end
    run_fill(32'h2468ACE0, 3'd1, 3'd1, 0, 15, 0, r);
    total++; if (r.done_n !== 0) begin bad++; $display("FAIL abort_last_no_done: got %0d want 0", r.done_n); end
    total++; if (r.abort_n !== 1) begin bad++; $display("FAIL abort_last_pulse: got %0d want 1", r.abort_n); end
    total++; if (r.beats !== 16) begin bad++; $display("FAIL abort_last_beats: got %0d want 16", r.beats); end
  endtask

  task automatic test_seed_zero();
    res_t r;
    run_fill(32'h0, 3'd2, 3'd1, 0, -1, 0, r);
    total++; if (r.errs !== 0) begin bad++; $display("FAIL seed0_data: got %h want %h", r.bad_act, r.bad_exp); end
    total++; if (r.nz == 0) begin bad++; $display("FAIL seed0_stuck: got %0d nonzero lane0 beats want >0", r.nz); end
  endtask

  task automatic test_start_ignored();
    res_t r;
    run_fill(32'h89ABCDEF, 3'd1, 3'd1, 0, -1, 1, r);
    total++; if (r.beats !== 16) begin bad++; $display("FAIL start_fill_beats: got %0d want 16", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL start_fill_data: got %h want %h", r.bad_act, r.bad_exp); end
    total++; if (r.done_n !== 1) begin bad++; $display("FAIL start_fill_done: got %0d want 1", r.done_n); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    run_fill(32'h11111111, 3'd0, 3'd1, 0, -1, 0, r);
    run_fill(32'h22222222, 3'd0, 3'd2, 0, -1, 0, r);
    total++; if (r.done_cyc !== 9) begin bad++; $display("FAIL b2b_done_cycle: got %0d want 9", r.done_cyc); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL b2b_data: got %h want %h", r.bad_act, r.bad_exp); end
  endtask

  task automatic test_reset_mid();
    res_t r;
    seed = 32'h1234; size = 3'd2; ch_count = 3'd1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (6) @(posedge clk);
    #3;
    total++; if (bram_we !== 1) begin bad++; $display("FAIL midrst_pre_we: got %b want 1", bram_we); end
    rst_n = 0;
    #1;
    total++; if (bram_we !== 0) begin bad++; $display("FAIL midrst_we: got %b want 0", bram_we); end
    total++; if (busy !== 0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (bram_addr !== 0) begin bad++; $display("FAIL midrst_addr: got %0h want 0", bram_addr); end
    @(posedge clk); #1;
    total++; if (done !== 0 || aborted !== 0) begin bad++; $display("FAIL midrst_pulse: got %b%b want 00", done, aborted); end
    rst_n = 1;
    @(posedge clk); #1;
    run_fill(32'h5555AAAA, 3'd0, 3'd1, 0, -1, 0, r);
    total++; if (r.beats !== 4) begin bad++; $display("FAIL midrst_refill_beats: got %0d want 4", r.beats); end
    total++; if (r.errs !== 0) begin bad++; $display("FAIL midrst_refill_data: got %h want %h", r.bad_act, r.bad_exp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_multi_lane();
    test_clamp();
    test_backpressure();
    test_abort();
    test_seed_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
